// File: rtl/gate_sweep_gen.sv
// gate_sweep_gen: exhaustive N-input gate stimulus sweep with golden NAND/NOR/XOR/XNOR result.
// Optional GATE_SWEEP_CHECK_EN adds dut_y comparison with mismatch pulse and err_cnt.
module gate_sweep_gen #(
    parameter int N    = 3,
    parameter int HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
`ifdef GATE_SWEEP_CHECK_EN
    input  logic         dut_y,
    output logic         mismatch,
    output logic [N:0]   err_cnt,
`endif
    output logic [N-1:0] vec,
    output logic         y,
    output logic         valid,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_cnt
);
    localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HLAST = HW'(HOLD - 1);
    localparam logic [N-1:0] VMAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [HW-1:0] hcnt;
    logic [1:0]  mode_q;

    function automatic logic gate_f(input logic [1:0] m, input logic [N-1:0] v);
        return m[1] ? ((^v) ^ m[0]) : (m[0] ? ~|v : ~&v);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hcnt     <= '0;
            mode_q   <= '0;
            vec      <= '0;
            y        <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ones_cnt <= '0;
`ifdef GATE_SWEEP_CHECK_EN
            mismatch <= 1'b0;
            err_cnt  <= '0;
`endif
        end else begin
`ifdef GATE_SWEEP_CHECK_EN
            mismatch <= valid && (dut_y != y);
            err_cnt  <= err_cnt + (N+1)'(valid && (dut_y != y));
`endif
            case (state)
                IDLE: if (start) begin
                    state    <= RUN;
                    vec      <= '0;
                    hcnt     <= '0;
                    mode_q   <= mode;
                    ones_cnt <= '0;
                    y        <= gate_f(mode, '0);
                    busy     <= 1'b1;
                    valid    <= (HOLD == 1);
`ifdef GATE_SWEEP_CHECK_EN
                    err_cnt  <= '0;
`endif
                end
                RUN: if (hcnt == HLAST) begin
                    ones_cnt <= ones_cnt + (N+1)'(y);
                    if (vec == VMAX) begin
                        state <= DONE;
                        done  <= 1'b1;
                        valid <= 1'b0;
                    end else begin
                        vec   <= vec + 1'b1;
                        y     <= gate_f(mode_q, vec + 1'b1);
                        hcnt  <= '0;
                        valid <= (HOLD == 1);
                    end
                end else begin
                    hcnt  <= hcnt + HW'(1);
                    valid <= (hcnt + HW'(1)) == HLAST;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
